// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB with 2-bit saturating counters: Fetch-side prediction, Execute-side check and training.
// Optional macro BPU_PERF_EN adds saturating branch/mispredict counters; otherwise both are tied to zero.
module branch_predictor_unit #(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] PCF,
   output logic            PredTakenF,
   output logic [XLEN-1:0] PredTargetF,
   input  logic            InstrValidE,
   input  logic            FlushE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic            PredTakenE,
   input  logic [XLEN-1:0] PredTargetE,
   output logic            MispredictE,
   output logic [XLEN-1:0] RedirectPCE,
   output logic [31:0]     PerfBranchCnt,
   output logic [31:0]     PerfMissCnt
);
   localparam int IDX_W = $clog2(ENTRIES);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  target;
      logic [1:0]       ctr;
   } entry_t;

   entry_t entry_arr [ENTRIES];

   logic [IDX_W-1:0] idx_f, idx_e;
   logic [TAG_W-1:0] tag_f, tag_e;
   entry_t           ent_f, ent_e;
   logic             hit_f, hit_e;
   logic             act, is_cti, mispredict;

   logic   wr_en;
   entry_t wr_entry;

   assign idx_f = PCF[IDX_W+1:2];
   assign tag_f = PCF[IDX_W+TAG_W+1:IDX_W+2];
   assign idx_e = PCE[IDX_W+1:2];
   assign tag_e = PCE[IDX_W+TAG_W+1:IDX_W+2];

   assign ent_f = entry_arr[idx_f];
   assign ent_e = entry_arr[idx_e];
   assign hit_f = ent_f.valid && (ent_f.tag == tag_f);
   assign hit_e = ent_e.valid && (ent_e.tag == tag_e);

   // Prediction is suppressed while reset is held so Fetch falls through sequentially.
   assign PredTakenF  = rst_n & hit_f & ent_f.ctr[1];
   assign PredTargetF = PredTakenF ? ent_f.target : PCF + XLEN'(4);

   assign act    = InstrValidE & ~FlushE;
   assign is_cti = BranchE | JumpE;

   always_comb begin
      mispredict = 1'b0;
      if (act) begin
         if (is_cti) begin
            mispredict = (PredTakenE != PCSrcE) |
                         (PCSrcE & PredTakenE & (PredTargetE != PCTargetE));
         end else begin
            mispredict = PredTakenE;
         end
      end
   end

   assign MispredictE = mispredict;
   assign RedirectPCE = (act & is_cti & PCSrcE) ? PCTargetE : PCE + XLEN'(4);

   // Jumps take priority over the branch counter update if both flags are set.
   always_comb begin
      wr_en    = 1'b0;
      wr_entry = ent_e;
      if (act) begin
         if (is_cti) begin
            if (hit_e) begin
               wr_en = 1'b1;
               if (JumpE) begin
                  wr_entry.ctr    = 2'b11;
                  wr_entry.target = PCTargetE;
               end else if (PCSrcE) begin
                  wr_entry.ctr    = (ent_e.ctr == 2'b11) ? 2'b11 : ent_e.ctr + 2'd1;
                  wr_entry.target = PCTargetE;
               end else begin
                  wr_entry.ctr    = (ent_e.ctr == 2'b00) ? 2'b00 : ent_e.ctr - 2'd1;
               end
            end else if (PCSrcE) begin
               wr_en           = 1'b1;
               wr_entry.valid  = 1'b1;
               wr_entry.tag    = tag_e;
               wr_entry.target = PCTargetE;
               wr_entry.ctr    = JumpE ? 2'b11 : 2'b10;
            end
         end else if (hit_e) begin
            wr_en          = 1'b1;
            wr_entry.valid = 1'b0;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         entry_t entry_reg;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               entry_reg.valid  <= 1'b0;
               entry_reg.tag    <= '0;
               entry_reg.target <= '0;
               entry_reg.ctr    <= 2'b01;
            end else if (wr_en && (idx_e == IDX_W'(gi))) begin
               entry_reg <= wr_entry;
            end
         end

         assign entry_arr[gi] = entry_reg;
      end
   endgenerate

`ifdef BPU_PERF_EN
   logic [31:0] branch_cnt_reg, miss_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branch_cnt_reg <= '0;
         miss_cnt_reg   <= '0;
      end else if (act) begin
         if (is_cti && (branch_cnt_reg != 32'hFFFF_FFFF))
            branch_cnt_reg <= branch_cnt_reg + 32'd1;
         if (mispredict && (miss_cnt_reg != 32'hFFFF_FFFF))
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
   end

   assign PerfBranchCnt = branch_cnt_reg;
   assign PerfMissCnt   = miss_cnt_reg;
`else
   assign PerfBranchCnt = 32'h0;
   assign PerfMissCnt   = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed testbench for branch_predictor_unit; expected perf counts depend on BPU_PERF_EN.
module tb_branch_predictor_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PCF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        InstrValidE, FlushE, BranchE, JumpE, PCSrcE;
   logic [31:0] PCE, PCTargetE;
   logic        PredTakenE;
   logic [31:0] PredTargetE;
   logic        MispredictE;
   logic [31:0] RedirectPCE;
   logic [31:0] PerfBranchCnt, PerfMissCnt;

   int checks   = 0;
   int failures = 0;
   int exp_br   = 0;
   int exp_mis  = 0;

   typedef struct packed {
      logic        src;
      logic [31:0] tgt;
      logic        ptk;
      logic [31:0] ptg;
      logic        mis;
      logic [31:0] redir;
      logic        ptf;
      logic [31:0] ptgt;
   } vec_t;

   vec_t vecs [9];

   branch_predictor_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PCF           (PCF),
      .PredTakenF    (PredTakenF),
      .PredTargetF   (PredTargetF),
      .InstrValidE   (InstrValidE),
      .FlushE        (FlushE),
      .BranchE       (BranchE),
      .JumpE         (JumpE),
      .PCSrcE        (PCSrcE),
      .PCE           (PCE),
      .PCTargetE     (PCTargetE),
      .PredTakenE    (PredTakenE),
      .PredTargetE   (PredTargetE),
      .MispredictE   (MispredictE),
      .RedirectPCE   (RedirectPCE),
      .PerfBranchCnt (PerfBranchCnt),
      .PerfMissCnt   (PerfMissCnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic f, input logic b, input logic j,
                        input logic s, input logic [31:0] pce, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptg);
      InstrValidE = v; FlushE = f; BranchE = b; JumpE = j; PCSrcE = s;
      PCE = pce; PCTargetE = tgt; PredTakenE = pt; PredTargetE = ptg;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      PCF   = 32'h100;
      // Training attempted while reset is held must be discarded.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
      step();
      step();
      checks++;
      if (PredTakenF !== 1'b0) begin
         $display("FAIL reset_pred_taken: got %b expected 0", PredTakenF); failures++;
      end
      checks++;
      if (PredTargetF !== 32'h104) begin
         $display("FAIL reset_pred_target: got %h expected 00000104", PredTargetF); failures++;
      end
      checks++;
      if (MispredictE !== 1'b1 || RedirectPCE !== 32'h80) begin
         $display("FAIL reset_exec_comb: got mis=%b redir=%h expected mis=1 redir=00000080",
                  MispredictE, RedirectPCE); failures++;
      end
      checks++;
      if (PerfBranchCnt !== 32'h0 || PerfMissCnt !== 32'h0) begin
         $display("FAIL reset_perf: got %0d/%0d expected 0/0", PerfBranchCnt, PerfMissCnt); failures++;
      end
      idle();
      rst_n = 1'b1;
      step();
      checks++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin
         $display("FAIL reset_no_train: got tk=%b tgt=%h expected tk=0 tgt=00000104",
                  PredTakenF, PredTargetF); failures++;
      end
      $display("txn reset: done");
   endtask

   task automatic test_allocate();
      PCF = 32'h100;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
      exp_br++; exp_mis++;
      checks++;
      if (MispredictE !== 1'b1 || RedirectPCE !== 32'h80) begin
         $display("FAIL alloc_exec: got mis=%b redir=%h expected mis=1 redir=00000080",
                  MispredictE, RedirectPCE); failures++;
      end
      checks++;
      if (PredTakenF !== 1'b0) begin
         $display("FAIL alloc_read_old: got %b expected 0", PredTakenF); failures++;
      end
      step();
      idle();
      checks++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin
         $display("FAIL alloc_pred: got tk=%b tgt=%h expected tk=1 tgt=00000080",
                  PredTakenF, PredTargetF); failures++;
      end
      $display("txn allocate: pc=00000100 tgt=00000080");
   endtask

   task automatic test_counter();
      // ctr starts at 10: NT,NT,NT (01,00,00) then T x4 (01,10,11,11), NT (10), T new target (11).
      vecs[0] = '{1'b0, 32'h80, 1'b1, 32'h80,  1'b1, 32'h104, 1'b0, 32'h104};
      vecs[1] = '{1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104};
      vecs[2] = '{1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104};
      vecs[3] = '{1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80,  1'b0, 32'h104};
      vecs[4] = '{1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80,  1'b1, 32'h80};
      vecs[5] = '{1'b1, 32'h80, 1'b1, 32'h80,  1'b0, 32'h80,  1'b1, 32'h80};
      vecs[6] = '{1'b1, 32'h80, 1'b1, 32'h80,  1'b0, 32'h80,  1'b1, 32'h80};
      vecs[7] = '{1'b0, 32'h80, 1'b1, 32'h80,  1'b1, 32'h104, 1'b1, 32'h80};
      vecs[8] = '{1'b1, 32'h90, 1'b1, 32'h80,  1'b1, 32'h90,  1'b1, 32'h90};
      PCF = 32'h100;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, vecs[i].src, 32'h100, vecs[i].tgt, vecs[i].ptk, vecs[i].ptg);
         exp_br++;
         if (vecs[i].mis) exp_mis++;
         checks++;
         if (MispredictE !== vecs[i].mis || RedirectPCE !== vecs[i].redir) begin
            $display("FAIL ctr_exec[%0d]: got mis=%b redir=%h expected mis=%b redir=%h",
                     i, MispredictE, RedirectPCE, vecs[i].mis, vecs[i].redir); failures++;
         end
         step();
         idle();
         checks++;
         if (PredTakenF !== vecs[i].ptf || PredTargetF !== vecs[i].ptgt) begin
            $display("FAIL ctr_pred[%0d]: got tk=%b tgt=%h expected tk=%b tgt=%h",
                     i, PredTakenF, PredTargetF, vecs[i].ptf, vecs[i].ptgt); failures++;
         end
         $display("txn counter[%0d]: taken=%b pred_tk=%b", i, vecs[i].src, PredTakenF);
      end
   endtask

   task automatic test_nonbranch();
      PCF = 32'h100;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h90);
      exp_mis++;
      checks++;
      if (MispredictE !== 1'b1 || RedirectPCE !== 32'h104) begin
         $display("FAIL nonbr_exec: got mis=%b redir=%h expected mis=1 redir=00000104",
                  MispredictE, RedirectPCE); failures++;
      end
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h104);
      checks++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin
         $display("FAIL nonbr_evict: got tk=%b tgt=%h expected tk=0 tgt=00000104",
                  PredTakenF, PredTargetF); failures++;
      end
      checks++;
      if (MispredictE !== 1'b0) begin
         $display("FAIL nonbr_clean: got %b expected 0", MispredictE); failures++;
      end
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
      PCF = 32'hFFFF_FFFC;
      #1;
      checks++;
      if (RedirectPCE !== 32'h0 || PredTargetF !== 32'h0) begin
         $display("FAIL wrap: got redir=%h pred_tgt=%h expected 00000000/00000000",
                  RedirectPCE, PredTargetF); failures++;
      end
      step();
      idle();
      $display("txn nonbranch: alias evicted");
   endtask

   task automatic test_jump();
      PCF = 32'h200;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h300, 1'b0, 32'h204);
      exp_br++; exp_mis++;
      checks++;
      if (MispredictE !== 1'b1 || RedirectPCE !== 32'h300) begin
         $display("FAIL jump_exec: got mis=%b redir=%h expected mis=1 redir=00000300",
                  MispredictE, RedirectPCE); failures++;
      end
      step();
      // Branch not-taken on a jump-allocated entry: 11 -> 10 keeps it predicted taken.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h300, 1'b1, 32'h300);
      exp_br++; exp_mis++;
      checks++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h300) begin
         $display("FAIL jump_pred: got tk=%b tgt=%h expected tk=1 tgt=00000300",
                  PredTakenF, PredTargetF); failures++;
      end
      step();
      idle();
      checks++;
      if (PredTakenF !== 1'b1) begin
         $display("FAIL jump_ctr11: got %b expected 1", PredTakenF); failures++;
      end
      PCF = 32'h240;
      #1;
      checks++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h244) begin
         $display("FAIL tag_miss: got tk=%b tgt=%h expected tk=0 tgt=00000244",
                  PredTakenF, PredTargetF); failures++;
      end
      $display("txn jump: pc=00000200 tgt=00000300");
   endtask

   task automatic test_squash();
      PCF = 32'h400;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 32'h500, 1'b0, 32'h404);
         else        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'h500, 1'b0, 32'h404);
         checks++;
         if (MispredictE !== 1'b0 || RedirectPCE !== 32'h404) begin
            $display("FAIL squash_exec[%0d]: got mis=%b redir=%h expected mis=0 redir=00000404",
                     k, MispredictE, RedirectPCE); failures++;
         end
         step();
         checks++;
         if (PredTakenF !== 1'b0) begin
            $display("FAIL squash_no_train[%0d]: got %b expected 0", k, PredTakenF); failures++;
         end
         $display("txn squash[%0d]: no effect", k);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      PCF = 32'h600;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 32'h700, 1'b0, 32'h604);
      exp_br++; exp_mis++;
      checks++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h604) begin
         $display("FAIL same_cycle_old: got tk=%b tgt=%h expected tk=0 tgt=00000604",
                  PredTakenF, PredTargetF); failures++;
      end
      step();
      idle();
      checks++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h700) begin
         $display("FAIL same_cycle_new: got tk=%b tgt=%h expected tk=1 tgt=00000700",
                  PredTakenF, PredTargetF); failures++;
      end
      $display("txn back_to_back: pc=00000600");
   endtask

   task automatic test_perf();
      logic [31:0] want_br, want_mis;
`ifdef BPU_PERF_EN
      want_br  = 32'(exp_br);
      want_mis = 32'(exp_mis);
`else
      want_br  = 32'h0;
      want_mis = 32'h0;
`endif
      checks++;
      if (PerfBranchCnt !== want_br || PerfMissCnt !== want_mis) begin
         $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d",
                  PerfBranchCnt, PerfMissCnt, want_br, want_mis); failures++;
      end
      $display("txn perf: branches=%0d misses=%0d", PerfBranchCnt, PerfMissCnt);
   endtask

   task automatic test_reset_clear();
      rst_n = 1'b0;
      PCF   = 32'h800;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h800, 32'h900, 1'b0, 32'h804);
      step();
      idle();
      rst_n = 1'b1;
      step();
      checks++;
      if (PredTakenF !== 1'b0) begin
         $display("FAIL reset_cancel_write: got %b expected 0", PredTakenF); failures++;
      end
      PCF = 32'h600;
      #1;
      checks++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h604) begin
         $display("FAIL reset_clears_table: got tk=%b tgt=%h expected tk=0 tgt=00000604",
                  PredTakenF, PredTargetF); failures++;
      end
      checks++;
      if (PerfBranchCnt !== 32'h0 || PerfMissCnt !== 32'h0) begin
         $display("FAIL reset_clears_perf: got %0d/%0d expected 0/0", PerfBranchCnt, PerfMissCnt);
         failures++;
      end
      $display("txn reset_clear: done");
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_counter();
      test_nonbranch();
      test_jump();
      test_squash();
      test_back_to_back();
      test_perf();
      test_reset_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
